// File: rtl/reg_file_mp_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_mp_pkg
// Shared definitions for the multi-port register file and the datapath
// blocks that address it (ALU, control unit).
//   DATA_W_DEF / ADDR_W_DEF / NUM_RD_DEF : default geometry
//   reg_idx_t                            : register index at default geometry
//   rd_src_e                             : where a read port takes its data from
// ---------------------------------------------------------------------------
package reg_file_mp_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NUM_RD_DEF = 2;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  // Read-port data source, in decreasing priority order.
  typedef enum logic [1:0] {
    SRC_ZERO  = 2'd0,  // hardwired zero register
    SRC_WR1   = 2'd1,  // forwarded from write port 1
    SRC_WR0   = 2'd2,  // forwarded from write port 0
    SRC_ARRAY = 2'd3   // stored register contents
  } rd_src_e;

endpackage

// File: rtl/reg_file_rdport.sv
// ---------------------------------------------------------------------------
// reg_file_rdport
// One combinational read port: picks between the zero register, same-cycle
// write forwarding and the stored register/busy bit.
//   raddr                  : register being read
//   we0/waddr0/wdata0      : write port 0 (lower priority)
//   we1/waddr1/wdata1      : write port 1 (higher priority)
//   stored_data/stored_busy: regs[raddr] and busy[raddr] from the top level
//   rdata/rbusy            : read result and advisory busy flag
// ---------------------------------------------------------------------------
module reg_file_rdport
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              stored_busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy
);

  rd_src_e src;

  // Forwarded data is about to be written, so it has no outstanding
  // producer and the busy flag is suppressed.
  always_comb begin
    src = SRC_ARRAY;
    if ((ZERO_REG != 0) && (raddr == '0)) begin
      src = SRC_ZERO;
    end else if ((BYPASS != 0) && we1 && (waddr1 == raddr)) begin
      src = SRC_WR1;
    end else if ((BYPASS != 0) && we0 && (waddr0 == raddr)) begin
      src = SRC_WR0;
    end
  end

  always_comb begin
    rdata = stored_data;
    rbusy = stored_busy;
    case (src)
      SRC_ZERO: begin
        rdata = '0;
        rbusy = 1'b0;
      end
      SRC_WR1: begin
        rdata = wdata1;
        rbusy = 1'b0;
      end
      SRC_WR0: begin
        rdata = wdata0;
        rbusy = 1'b0;
      end
      default: begin
        rdata = stored_data;
        rbusy = stored_busy;
      end
    endcase
  end

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Parametrised multi-port register file with two write ports, optional
// write-to-read bypass, optional hardwired zero register and a per-register
// busy scoreboard.
//   CLK, RESET        : clock; synchronous active-high reset
//   WE0/WADDR0/WDATA0 : write port 0
//   WE1/WADDR1/WDATA1 : write port 1, wins on a same-address dual write
//   RADDR / RDATA     : NUM_RD packed read addresses / read data
//   RSV_EN / RSV_ADDR : mark a register busy (outstanding producer)
//   RBUSY             : per-read-port busy flag of the addressed register
//   COLLISION         : high for the cycle after a same-address dual write
// ---------------------------------------------------------------------------
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WE0,
  input  logic [ADDR_W-1:0]        WADDR0,
  input  logic [DATA_W-1:0]        WDATA0,
  input  logic                     WE1,
  input  logic [ADDR_W-1:0]        WADDR1,
  input  logic [DATA_W-1:0]        WDATA1,
  input  logic [NUM_RD*ADDR_W-1:0] RADDR,
  output logic [NUM_RD*DATA_W-1:0] RDATA,
  input  logic                     RSV_EN,
  input  logic [ADDR_W-1:0]        RSV_ADDR,
  output logic [NUM_RD-1:0]        RBUSY,
  output logic                     COLLISION
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              collision_q;

  logic we0_eff;
  logic we1_eff;
  logic rsv_eff;
  logic same_addr;

  // With the zero register enabled, anything aimed at register 0 is dropped
  // so it can never hold data or become busy.
  assign we0_eff   = WE0    && !((ZERO_REG != 0) && (WADDR0   == '0));
  assign we1_eff   = WE1    && !((ZERO_REG != 0) && (WADDR1   == '0));
  assign rsv_eff   = RSV_EN && !((ZERO_REG != 0) && (RSV_ADDR == '0));
  assign same_addr = (WADDR0 == WADDR1);

  // Reserve is applied after the write clears, so a same-cycle write and
  // reserve leaves the register busy: the reserve is the newer producer.
  always_comb begin
    busy_nxt = busy;
    if (we0_eff) busy_nxt[WADDR0] = 1'b0;
    if (we1_eff) busy_nxt[WADDR1] = 1'b0;
    if (rsv_eff) busy_nxt[RSV_ADDR] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy        <= '0;
      collision_q <= 1'b0;
    end else begin
      if (we0_eff && !(we1_eff && same_addr)) begin
        regs[WADDR0] <= WDATA0;
      end
      if (we1_eff) begin
        regs[WADDR1] <= WDATA1;
      end
      busy        <= busy_nxt;
      // Flags any same-address dual write request, even one aimed at the
      // zero register, so the control unit sees the port conflict.
      collision_q <= WE0 && WE1 && same_addr;
    end
  end

  assign COLLISION = collision_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = RADDR[g*ADDR_W +: ADDR_W];

    reg_file_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rdport (
      .raddr      (ra),
      .we0        (WE0),
      .waddr0     (WADDR0),
      .wdata0     (WDATA0),
      .we1        (WE1),
      .waddr1     (WADDR1),
      .wdata1     (WDATA1),
      .stored_data(regs[ra]),
      .stored_busy(busy[ra]),
      .rdata      (RDATA[g*DATA_W +: DATA_W]),
      .rbusy      (RBUSY[g])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: instance A uses default parameters (bypass on),
// instance B uses DATA_W=16, ADDR_W=4, NUM_RD=3, no bypass, zero register.
module tb_reg_file_mp;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  // Instance A
  logic        a_we0, a_we1, a_rsv;
  logic [2:0]  a_wa0, a_wa1, a_ra;
  logic [7:0]  a_wd0, a_wd1;
  logic [5:0]  a_raddr;
  logic [15:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic        a_coll;

  // Instance B
  logic        b_we0, b_we1, b_rsv;
  logic [3:0]  b_wa0, b_wa1, b_ra;
  logic [15:0] b_wd0, b_wd1;
  logic [11:0] b_raddr;
  logic [47:0] b_rdata;
  logic [2:0]  b_rbusy;
  logic        b_coll;

  reg_file_mp u_a (
    .CLK(CLK), .RESET(RESET),
    .WE0(a_we0), .WADDR0(a_wa0), .WDATA0(a_wd0),
    .WE1(a_we1), .WADDR1(a_wa1), .WDATA1(a_wd1),
    .RADDR(a_raddr), .RDATA(a_rdata),
    .RSV_EN(a_rsv), .RSV_ADDR(a_ra),
    .RBUSY(a_rbusy), .COLLISION(a_coll)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(3), .BYPASS(0), .ZERO_REG(1)) u_b (
    .CLK(CLK), .RESET(RESET),
    .WE0(b_we0), .WADDR0(b_wa0), .WDATA0(b_wd0),
    .WE1(b_we1), .WADDR1(b_wa1), .WDATA1(b_wd1),
    .RADDR(b_raddr), .RDATA(b_rdata),
    .RSV_EN(b_rsv), .RSV_ADDR(b_ra),
    .RBUSY(b_rbusy), .COLLISION(b_coll)
  );

  // Reference model: index 0 = A, 1 = B
  logic [15:0] m_regs [2][16];
  bit          m_busy [2][16];
  bit          m_coll [2];
  int          m_depth  [2] = '{8, 16};
  bit          m_bypass [2] = '{1'b1, 1'b0};
  bit          m_zero   [2] = '{1'b0, 1'b1};

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_read(input int k, input int a,
                          input bit we0, input int wa0, input logic [15:0] wd0,
                          input bit we1, input int wa1, input logic [15:0] wd1,
                          output logic [15:0] d, output bit b);
    if (m_zero[k] && a == 0) begin
      d = 16'h0; b = 1'b0;
    end else if (m_bypass[k] && we1 && wa1 == a) begin
      d = wd1; b = 1'b0;
    end else if (m_bypass[k] && we0 && wa0 == a) begin
      d = wd0; b = 1'b0;
    end else begin
      d = m_regs[k][a]; b = m_busy[k][a];
    end
  endtask

  task automatic model_edge(input int k, input bit rst,
                            input bit we0, input int wa0, input logic [15:0] wd0,
                            input bit we1, input int wa1, input logic [15:0] wd1,
                            input bit rsv, input int ra);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[k][i] = 16'h0;
        m_busy[k][i] = 1'b0;
      end
      m_coll[k] = 1'b0;
    end else begin
      m_coll[k] = we0 && we1 && (wa0 == wa1);
      // Port 1 applied last so it wins on the same address.
      if (we0 && !(m_zero[k] && wa0 == 0)) begin
        m_regs[k][wa0] = wd0; m_busy[k][wa0] = 1'b0;
      end
      if (we1 && !(m_zero[k] && wa1 == 0)) begin
        m_regs[k][wa1] = wd1; m_busy[k][wa1] = 1'b0;
      end
      if (rsv && !(m_zero[k] && ra == 0)) m_busy[k][ra] = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [15:0] d;
    bit b;
    for (int p = 0; p < 2; p++) begin
      exp_read(0, int'(a_raddr[p*3 +: 3]), a_we0, int'(a_wa0), {8'h0, a_wd0},
               a_we1, int'(a_wa1), {8'h0, a_wd1}, d, b);
      chk($sformatf("A_rdata%0d", p), {24'h0, a_rdata[p*8 +: 8]}, {16'h0, d});
      chk($sformatf("A_rbusy%0d", p), {31'h0, a_rbusy[p]}, {31'h0, b});
    end
    chk("A_collision", {31'h0, a_coll}, {31'h0, m_coll[0]});
    for (int p = 0; p < 3; p++) begin
      exp_read(1, int'(b_raddr[p*4 +: 4]), b_we0, int'(b_wa0), b_wd0,
               b_we1, int'(b_wa1), b_wd1, d, b);
      chk($sformatf("B_rdata%0d", p), {16'h0, b_rdata[p*16 +: 16]}, {16'h0, d});
      chk($sformatf("B_rbusy%0d", p), {31'h0, b_rbusy[p]}, {31'h0, b});
    end
    chk("B_collision", {31'h0, b_coll}, {31'h0, m_coll[1]});
  endtask

  // Called right after a falling edge with inputs set; returns at the next
  // falling edge.
  task automatic tick(input bit do_check);
    #1;
    if (do_check) check_all();
    @(posedge CLK);
    model_edge(0, RESET, a_we0, int'(a_wa0), {8'h0, a_wd0}, a_we1, int'(a_wa1),
               {8'h0, a_wd1}, a_rsv, int'(a_ra));
    model_edge(1, RESET, b_we0, int'(b_wa0), b_wd0, b_we1, int'(b_wa1), b_wd1,
               b_rsv, int'(b_ra));
    @(negedge CLK);
  endtask

  task automatic idle();
    RESET = 1'b0;
    a_we0 = 0; a_we1 = 0; a_rsv = 0; a_wa0 = 0; a_wa1 = 0; a_ra = 0; a_wd0 = 0; a_wd1 = 0;
    b_we0 = 0; b_we1 = 0; b_rsv = 0; b_wa0 = 0; b_wa1 = 0; b_ra = 0; b_wd0 = 0; b_wd1 = 0;
  endtask

  initial begin
    idle();
    a_raddr = '0;
    b_raddr = '0;
    for (int i = 0; i < 16; i++) begin
      m_regs[0][i] = 16'h0; m_regs[1][i] = 16'h0;
      m_busy[0][i] = 1'b0;  m_busy[1][i] = 1'b0;
    end
    m_coll[0] = 1'b0; m_coll[1] = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    tick(1'b0);

    // Reset sweep: fill every register with 5F, reserve some, then reset.
    idle();
    for (int i = 0; i < 16; i++) begin
      a_we0 = 1; a_wa0 = 3'(i); a_wd0 = 8'h5F;
      b_we0 = 1; b_wa0 = 4'(i); b_wd0 = 16'h005F;
      a_rsv = 1; a_ra = 3'(i + 3);
      b_rsv = 1; b_ra = 4'(i + 5);
      tick(1'b1);
    end
    idle();
    RESET = 1'b1;
    a_we0 = 1; a_wa0 = 3'd1; a_wd0 = 8'h77;
    tick(1'b1);
    idle();
    for (int i = 0; i < 16; i++) begin
      a_raddr = {3'(i), 3'(i + 1)};
      b_raddr = {4'(i), 4'(i + 1), 4'(i + 2)};
      #1;
      chk("rst_A_rdata", {16'h0, a_rdata}, 32'h0);
      chk("rst_A_rbusy", {30'h0, a_rbusy}, 32'h0);
      chk("rst_B_rdata", b_rdata[31:0], 32'h0);
      chk("rst_B_rbusy", {29'h0, b_rbusy}, 32'h0);
      chk("rst_A_coll", {31'h0, a_coll}, 32'h0);
      tick(1'b1);
    end

    // Single write to reg2: A forwards same cycle, B only after the edge.
    a_we0 = 1; a_wa0 = 3'd2; a_wd0 = 8'd95; a_raddr = {3'd0, 3'd2};
    b_we0 = 1; b_wa0 = 4'd2; b_wd0 = 16'd95; b_raddr = {4'd0, 4'd0, 4'd2};
    #1;
    chk("wr_A_bypass", {24'h0, a_rdata[7:0]}, 32'd95);
    chk("wr_B_before", {16'h0, b_rdata[15:0]}, 32'd0);
    tick(1'b1);
    idle();
    #1;
    chk("wr_A_after", {24'h0, a_rdata[7:0]}, 32'd95);
    chk("wr_B_after", {16'h0, b_rdata[15:0]}, 32'd95);
    tick(1'b1);

    // Dual-write collision on reg1.
    a_we0 = 1; a_we1 = 1; a_wa0 = 3'd1; a_wa1 = 3'd1; a_wd0 = 8'd28; a_wd1 = 8'd50;
    a_raddr = {3'd1, 3'd1};
    tick(1'b1);
    idle();
    #1;
    chk("coll_reg1", {24'h0, a_rdata[15:8]}, 32'd50);
    chk("coll_high", {31'h0, a_coll}, 32'd1);
    tick(1'b1);
    chk("coll_low", {31'h0, a_coll}, 32'd0);

    // Scoreboard on reg4.
    a_rsv = 1; a_ra = 3'd4; a_raddr = {3'd0, 3'd4};
    tick(1'b1);
    idle();
    #1;
    chk("rsv_busy", {31'h0, a_rbusy[0]}, 32'd1);
    a_we0 = 1; a_wa0 = 3'd4; a_wd0 = 8'd6;
    tick(1'b1);
    idle();
    #1;
    chk("wr_clr_busy", {31'h0, a_rbusy[0]}, 32'd0);
    chk("wr_clr_data", {24'h0, a_rdata[7:0]}, 32'd6);
    a_we0 = 1; a_wa0 = 3'd4; a_wd0 = 8'd15; a_rsv = 1; a_ra = 3'd4;
    tick(1'b1);
    idle();
    #1;
    chk("rsv_wr_data", {24'h0, a_rdata[7:0]}, 32'd15);
    chk("rsv_wr_busy", {31'h0, a_rbusy[0]}, 32'd1);
    tick(1'b1);

    // Zero register on B.
    b_we0 = 1; b_wa0 = 4'd0; b_wd0 = 16'h00FF; b_rsv = 1; b_ra = 4'd0;
    tick(1'b1);
    idle();
    b_raddr = 12'h000;
    #1;
    chk("zero_rdata", b_rdata[31:0], 32'h0);
    chk("zero_rbusy", {29'h0, b_rbusy}, 32'h0);
    tick(1'b1);

    // Wide instance: reg15 read on all three ports.
    b_we1 = 1; b_wa1 = 4'd15; b_wd1 = 16'hBEEF;
    tick(1'b1);
    idle();
    b_raddr = {4'd15, 4'd15, 4'd15};
    #1;
    chk("wide_p0", {16'h0, b_rdata[15:0]},  32'hBEEF);
    chk("wide_p1", {16'h0, b_rdata[31:16]}, 32'hBEEF);
    chk("wide_p2", {16'h0, b_rdata[47:32]}, 32'hBEEF);
    tick(1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      RESET = ($urandom_range(0, 39) == 0);
      a_we0 = 1'($urandom_range(0, 1)); a_we1 = 1'($urandom_range(0, 1));
      a_wa0 = 3'($urandom_range(0, 7));
      a_wa1 = ($urandom_range(0, 3) == 0) ? a_wa0 : 3'($urandom_range(0, 7));
      a_wd0 = 8'($urandom); a_wd1 = 8'($urandom);
      a_rsv = 1'($urandom_range(0, 1)); a_ra = 3'($urandom_range(0, 7));
      a_raddr = 6'($urandom);
      b_we0 = 1'($urandom_range(0, 1)); b_we1 = 1'($urandom_range(0, 1));
      b_wa0 = 4'($urandom_range(0, 15));
      b_wa1 = ($urandom_range(0, 3) == 0) ? b_wa0 : 4'($urandom_range(0, 15));
      b_wd0 = 16'($urandom); b_wd1 = 16'($urandom);
      b_rsv = 1'($urandom_range(0, 1)); b_ra = 4'($urandom_range(0, 15));
      b_raddr = 12'($urandom);
      tick(1'b1);
    end
    idle();
    tick(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
